// File: rtl/cnt_arb_pkg.sv
// Shared types and constants for the counter bus arbiter slice.
// Build option: define CNT_ARB_LOCK_EN to enable per-requester ownership lock.
package cnt_arb_pkg;

    localparam int DATA_W = 8;
    localparam int MAX_N  = 8;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        ACK
    } state_t;

endpackage

// File: rtl/cnt_arb_if.sv
// Requester-side handshake bundle of the counter bus arbiter.
// req/req_wr/req_data(/req_lock) from clients; gnt/rd_valid/rd_data back.
interface cnt_arb_if
    import cnt_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = DATA_W
);
    logic [N-1:0]    req;
    logic [N-1:0]    req_wr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    gnt;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
`ifdef CNT_ARB_LOCK_EN
    logic [N-1:0]    req_lock;

    modport master (
        output req, req_wr, req_data, req_lock,
        input  gnt, rd_valid, rd_data
    );
    modport slave (
        input  req, req_wr, req_data, req_lock,
        output gnt, rd_valid, rd_data
    );
`else
    modport master (
        output req, req_wr, req_data,
        input  gnt, rd_valid, rd_data
    );
    modport slave (
        input  req, req_wr, req_data,
        output gnt, rd_valid, rd_data
    );
`endif
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr.
// Ports: req, ptr in; one-hot sel, binary idx, any out.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int            j;
        logic [IW-1:0] k;
        sel = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        k   = '0;
        for (int off = 0; off < N; off++) begin
            j = int'(ptr) + off;
            if (j >= N) j = j - N;
            k = IW'(j);
            if (!any && req[k]) begin
                any    = 1'b1;
                sel[k] = 1'b1;
                idx    = k;
            end
        end
    end

endmodule

// File: rtl/counter_bus_arbiter.sv
// Shares one loadable tri-state counter among N requesters (round-robin).
// Ports: clk, rst_n, bus (cnt_arb_if.slave), cnt_load/cnt_load_in/cnt_en
// out to the counter, cnt_bus in. Option: CNT_ARB_LOCK_EN (req_lock).
module counter_bus_arbiter
    import cnt_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    cnt_arb_if.slave      bus,
    output logic          cnt_load,
    output logic [DW-1:0] cnt_load_in,
    output logic          cnt_en,
    input  logic [DW-1:0] cnt_bus
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state, state_d;
    logic [IW-1:0] rr_ptr, rr_d;
    logic [IW-1:0] cur_idx, idx_d;
    logic [N-1:0]  cur_sel, sel_d;
    logic          cur_wr, wr_d;
    logic [IW-1:0] pick_idx, sel_idx;
    logic [N-1:0]  pick_sel, sel_oh, gnt_d;
    logic          pick_any, go;
    logic          load_d, en_d, rdv_d, cap;
    logic [DW-1:0] load_in_d;
    logic [DW-1:0] data_arr [N];

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req (bus.req),
        .ptr (rr_ptr),
        .sel (pick_sel),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        for (int i = 0; i < N; i++)
            data_arr[i] = bus.req_data[i*DW +: DW];
    end

`ifdef CNT_ARB_LOCK_EN
    logic lock_hold, lock_d;
    // A held lock re-selects the previous owner regardless of the pointer.
    assign go      = pick_any | lock_hold;
    assign sel_idx = lock_hold ? cur_idx : pick_idx;
    assign sel_oh  = lock_hold ? cur_sel : pick_sel;
`else
    assign go      = pick_any;
    assign sel_idx = pick_idx;
    assign sel_oh  = pick_sel;
`endif

    always_comb begin
        state_d   = state;
        rr_d      = rr_ptr;
        idx_d     = cur_idx;
        sel_d     = cur_sel;
        wr_d      = cur_wr;
        load_d    = 1'b0;
        load_in_d = '0;
        en_d      = 1'b0;
        gnt_d     = '0;
        rdv_d     = 1'b0;
        cap       = 1'b0;
`ifdef CNT_ARB_LOCK_EN
        lock_d    = lock_hold;
`endif
        unique case (state)
            IDLE: begin
                if (go) begin
                    idx_d   = sel_idx;
                    sel_d   = sel_oh;
                    wr_d    = bus.req_wr[sel_idx];
                    // Outputs are registered, so set them on entry to EXEC.
                    load_d  = wr_d;
                    en_d    = !wr_d;
                    if (wr_d) load_in_d = data_arr[sel_idx];
`ifdef CNT_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Bus is driven this cycle only; capture at its closing edge.
                cap     = !cur_wr;
                gnt_d   = cur_sel;
                rdv_d   = !cur_wr;
                state_d = ACK;
            end
            ACK: begin
                rr_d = (cur_idx == LAST) ? '0 : cur_idx + 1'b1;
`ifdef CNT_ARB_LOCK_EN
                if (bus.req_lock[cur_idx] && bus.req[cur_idx]) begin
                    lock_d = 1'b1;
                    rr_d   = rr_ptr;
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cur_idx      <= '0;
            cur_sel      <= '0;
            cur_wr       <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_load_in  <= '0;
            cnt_en       <= 1'b0;
            bus.gnt      <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
`ifdef CNT_ARB_LOCK_EN
            lock_hold    <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            rr_ptr       <= rr_d;
            cur_idx      <= idx_d;
            cur_sel      <= sel_d;
            cur_wr       <= wr_d;
            cnt_load     <= load_d;
            cnt_load_in  <= load_in_d;
            cnt_en       <= en_d;
            bus.gnt      <= gnt_d;
            bus.rd_valid <= rdv_d;
            if (cap) bus.rd_data <= cnt_bus;
`ifdef CNT_ARB_LOCK_EN
            lock_hold    <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_counter_bus_arbiter.sv
// Directed bench for counter_bus_arbiter with a behavioural tri-state counter.
// Table of single transactions plus reset, fairness and lock sequences.
module tb_counter_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cnt_load;
    logic [7:0] cnt_load_in;
    logic       cnt_en;
    wire  [7:0] cnt_bus;
    logic [7:0] cnt = 8'h00;

    int checks = 0;
    int errors = 0;

    cnt_arb_if #(.N(4), .DW(8)) bus ();

    counter_bus_arbiter #(.N(4), .DW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .cnt_load    (cnt_load),
        .cnt_load_in (cnt_load_in),
        .cnt_en      (cnt_en),
        .cnt_bus     (cnt_bus)
    );

    always #5 clk = ~clk;

    // Counter: loads or increments every edge, drives bus only when enabled.
    always @(posedge clk) cnt <= cnt_load ? cnt_load_in : cnt + 8'd1;
    assign cnt_bus = cnt_en ? cnt : 8'hzz;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (rst_n) chk("no_overlap", 32'(cnt_load & cnt_en), 32'd0);

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic        is_ld;
        logic [7:0]  ld;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs [11];

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bus.req      = v.req;
        bus.req_wr   = v.wr;
        bus.req_data = v.data;
        @(posedge clk); #1;
        chk("exec_load", 32'(cnt_load), 32'(v.is_ld));
        chk("exec_en", 32'(cnt_en), 32'(!v.is_ld));
        chk("exec_ld_in", 32'(cnt_load_in), v.is_ld ? 32'(v.ld) : 32'd0);
        chk("exec_gnt", 32'(bus.gnt), 32'd0);
        bus.req    = 4'b0000;
        bus.req_wr = 4'b1111;
        @(posedge clk); #1;
        chk("ack_gnt", 32'(bus.gnt), 32'(v.gnt));
        chk("ack_rdv", 32'(bus.rd_valid), 32'(!v.is_ld));
        chk("ack_load", 32'(cnt_load | cnt_en), 32'd0);
        if (!v.is_ld) chk("rd_data", 32'(bus.rd_data), 32'(v.rd));
        @(posedge clk); #1;
        chk("idle_gnt", 32'(bus.gnt), 32'd0);
        chk("idle_rdv", 32'(bus.rd_valid), 32'd0);
    endtask

    initial begin
        logic [3:0] fair [5];
        bus.req      = '0;
        bus.req_wr   = '0;
        bus.req_data = '0;
`ifdef CNT_ARB_LOCK_EN
        bus.req_lock = '0;
`endif
        vecs[0]  = '{4'b0001, 4'b0001, 32'h000000A5, 4'b0001, 1'b1, 8'hA5, 8'h00};
        vecs[1]  = '{4'b0010, 4'b0000, 32'h0,        4'b0010, 1'b0, 8'h00, 8'hA7};
        vecs[2]  = '{4'b0100, 4'b0100, 32'h003A0000, 4'b0100, 1'b1, 8'h3A, 8'h00};
        vecs[3]  = '{4'b0010, 4'b0000, 32'h0,        4'b0010, 1'b0, 8'h00, 8'h3C};
        vecs[4]  = '{4'b1000, 4'b1000, 32'hFE000000, 4'b1000, 1'b1, 8'hFE, 8'h00};
        vecs[5]  = '{4'b0001, 4'b0000, 32'h0,        4'b0001, 1'b0, 8'h00, 8'h00};
        vecs[6]  = '{4'b1001, 4'b0000, 32'h0,        4'b1000, 1'b0, 8'h00, 8'h03};
        vecs[7]  = '{4'b1001, 4'b0000, 32'h0,        4'b0001, 1'b0, 8'h00, 8'h06};
        vecs[8]  = '{4'b0101, 4'b0101, 32'h00220011, 4'b0100, 1'b1, 8'h22, 8'h00};
        vecs[9]  = '{4'b0011, 4'b0011, 32'h00005544, 4'b0001, 1'b1, 8'h44, 8'h00};
        vecs[10] = '{4'b0011, 4'b0000, 32'h0,        4'b0010, 1'b0, 8'h00, 8'h46};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_rdv", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_load", 32'(cnt_load), 32'd0);
        chk("rst_ld_in", 32'(cnt_load_in), 32'd0);
        chk("rst_en", 32'(cnt_en), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Reset in the middle of a load: everything drops, no grant follows.
        @(negedge clk);
        bus.req      = 4'b0001;
        bus.req_wr   = 4'b0001;
        bus.req_data = 32'h00000077;
        @(posedge clk); #1;
        chk("mid_load_on", 32'(cnt_load), 32'd1);
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        #1;
        chk("mid_load_drop", 32'(cnt_load), 32'd0);
        chk("mid_ld_in", 32'(cnt_load_in), 32'd0);
        chk("mid_rd_data", 32'(bus.rd_data), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_no_gnt", 32'(bus.gnt), 32'd0);
        end

        // All four requesting reads continuously: strict rotation.
        fair[0] = 4'b0001; fair[1] = 4'b0010; fair[2] = 4'b0100;
        fair[3] = 4'b1000; fair[4] = 4'b0001;
        @(negedge clk);
        bus.req    = 4'b1111;
        bus.req_wr = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("fair_exec", 32'(bus.gnt), 32'd0);
            @(posedge clk); #1;
            chk("fair_gnt", 32'(bus.gnt), 32'(fair[i]));
            chk("fair_rdv", 32'(bus.rd_valid), 32'd1);
            if (i == 4) bus.req = 4'b0000;
            @(posedge clk); #1;
            chk("fair_idle", 32'(bus.gnt), 32'd0);
        end
        repeat (3) @(posedge clk);

`ifdef CNT_ARB_LOCK_EN
        // Requester 0 holds the lock for three grants, then releases it.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        fair[0] = 4'b0001; fair[1] = 4'b0001;
        fair[2] = 4'b0001; fair[3] = 4'b0010;
        bus.req      = 4'b0011;
        bus.req_wr   = 4'b0000;
        bus.req_lock = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("lock_gnt", 32'(bus.gnt), 32'(fair[i]));
            if (i == 2) bus.req_lock = 4'b0000;
            if (i == 3) bus.req = 4'b0000;
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
